// File: rtl/dmac_ctrl_pkg.sv
// Shared types and helpers for the cluster DMA control-port concentrator.
// Struct widths follow the default mchan control-port geometry.
package dmac_ctrl_pkg;

  localparam int CTRL_DATA_W = 32;
  localparam int CTRL_BE_W   = CTRL_DATA_W / 8;
  localparam int CTRL_ADD_W  = 10;
  localparam int CTRL_ID_W   = 4;

  typedef struct packed {
    logic [CTRL_ADD_W-1:0]  add;
    logic                   we_n;
    logic [CTRL_BE_W-1:0]   be;
    logic [CTRL_DATA_W-1:0] wdata;
    logic [CTRL_ID_W-1:0]   id;
  } ctrl_req_t;

  typedef struct packed {
    logic [CTRL_DATA_W-1:0] rdata;
    logic                   opc;
    logic [CTRL_ID_W-1:0]   id;
  } ctrl_rsp_t;

  // A single port still needs a one-bit index so the arbiter vectors stay legal.
  function automatic int port_idx_width(input int nb_ports);
    return (nb_ports > 1) ? $clog2(nb_ports) : 1;
  endfunction

endpackage

// File: rtl/dmac_ctrl_rsp_fifo.sv
// In-order FIFO of granted port indices, used to route mchan responses back
// to the initiator that issued each request.
module dmac_ctrl_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // DEPTH is a power of two, so the pointers simply wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/dmac_ctrl_port_mux.sv
// Round-robin concentrator of NB_PORTS control initiators onto one mchan
// control port, with in-order response routing and bounded outstanding count.
module dmac_ctrl_port_mux
  import dmac_ctrl_pkg::*;
#(
  parameter int NB_PORTS       = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = DATA_WIDTH / 8,
  parameter int CTRL_ADD_WIDTH = 10,
  parameter int PE_ID_WIDTH    = 4,
  parameter int MAX_OUTSTND    = 4
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [NB_PORTS-1:0]                i_slv_req,
  input  logic [NB_PORTS*CTRL_ADD_WIDTH-1:0] i_slv_add,
  input  logic [NB_PORTS-1:0]                i_slv_we_n,
  input  logic [NB_PORTS*BE_WIDTH-1:0]       i_slv_be,
  input  logic [NB_PORTS*DATA_WIDTH-1:0]     i_slv_wdata,
  input  logic [NB_PORTS*PE_ID_WIDTH-1:0]    i_slv_id,
  output logic [NB_PORTS-1:0]                o_slv_gnt,
  output logic [NB_PORTS-1:0]                o_slv_r_valid,
  output logic [NB_PORTS*DATA_WIDTH-1:0]     o_slv_r_rdata,
  output logic [NB_PORTS-1:0]                o_slv_r_opc,
  output logic [NB_PORTS*PE_ID_WIDTH-1:0]    o_slv_r_id,
  output logic                               o_mst_req,
  output logic [CTRL_ADD_WIDTH-1:0]          o_mst_add,
  output logic                               o_mst_we_n,
  output logic [BE_WIDTH-1:0]                o_mst_be,
  output logic [DATA_WIDTH-1:0]              o_mst_wdata,
  output logic [PE_ID_WIDTH-1:0]             o_mst_id,
  input  logic                               i_mst_gnt,
  input  logic                               i_mst_r_valid,
  input  logic [DATA_WIDTH-1:0]              i_mst_r_rdata,
  input  logic                               i_mst_r_opc,
  input  logic [PE_ID_WIDTH-1:0]             i_mst_r_id,
  output logic                               o_busy,
  output logic                               o_rsp_err
);

  localparam int IDX_W = port_idx_width(NB_PORTS);
  localparam int CNT_W = $clog2(MAX_OUTSTND) + 1;

  logic [NB_PORTS-1:0] eligible;
  logic [IDX_W-1:0]    winner;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    head;
  logic [CNT_W-1:0]    count;
  logic                found;
  logic                handshake;
  logic                pop;
  logic                full;
  logic                empty;
  int                  cand;

  // Full comes from the registered count, so a same-cycle pop never opens a slot.
  assign eligible  = full ? '0 : i_slv_req;
  assign o_mst_req = |eligible;
  assign handshake = o_mst_req & i_mst_gnt;
  assign pop       = i_mst_r_valid & ~empty;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int k = 0; k < NB_PORTS; k++) begin
      cand = (int'(ptr) + k) % NB_PORTS;
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
  end

  assign o_slv_gnt   = handshake ? (NB_PORTS'(1) << winner) : '0;
  assign o_mst_add   = i_slv_add[winner*CTRL_ADD_WIDTH +: CTRL_ADD_WIDTH];
  assign o_mst_we_n  = i_slv_we_n[winner];
  assign o_mst_be    = i_slv_be[winner*BE_WIDTH +: BE_WIDTH];
  assign o_mst_wdata = i_slv_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
  assign o_mst_id    = i_slv_id[winner*PE_ID_WIDTH +: PE_ID_WIDTH];

  dmac_ctrl_rsp_fifo #(
    .DEPTH (MAX_OUTSTND),
    .WIDTH (IDX_W)
  ) u_rsp_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (handshake),
    .pop       (pop),
    .push_data (winner),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Explicit wrap: NB_PORTS need not be a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr <= '0;
    end else if (handshake) begin
      ptr <= (winner == IDX_W'(NB_PORTS - 1)) ? '0 : winner + 1'b1;
    end
  end

  // Unselected ports keep their last response payload; only r_valid drops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_slv_r_valid <= '0;
      o_slv_r_rdata <= '0;
      o_slv_r_opc   <= '0;
      o_slv_r_id    <= '0;
      o_rsp_err     <= 1'b0;
    end else begin
      o_rsp_err     <= i_mst_r_valid & empty;
      o_slv_r_valid <= '0;
      for (int p = 0; p < NB_PORTS; p++) begin
        if (pop && (head == IDX_W'(p))) begin
          o_slv_r_valid[p]                           <= 1'b1;
          o_slv_r_rdata[p*DATA_WIDTH +: DATA_WIDTH]   <= i_mst_r_rdata;
          o_slv_r_opc[p]                             <= i_mst_r_opc;
          o_slv_r_id[p*PE_ID_WIDTH +: PE_ID_WIDTH]    <= i_mst_r_id;
        end
      end
    end
  end

  assign o_busy = (count != '0) | (|o_slv_r_valid);

endmodule

// File: tb/tb_dmac_ctrl_port_mux.sv
// Directed self-checking bench for dmac_ctrl_port_mux with default parameters.
module tb_dmac_ctrl_port_mux;
  import dmac_ctrl_pkg::*;

  localparam int NP = 10;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int AW = 10;
  localparam int IW = 4;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b1;
  logic [NP-1:0]     slv_req;
  logic [NP*AW-1:0]  slv_add;
  logic [NP-1:0]     slv_we_n;
  logic [NP*BW-1:0]  slv_be;
  logic [NP*DW-1:0]  slv_wdata;
  logic [NP*IW-1:0]  slv_id;
  logic [NP-1:0]     slv_gnt;
  logic [NP-1:0]     slv_r_valid;
  logic [NP*DW-1:0]  slv_r_rdata;
  logic [NP-1:0]     slv_r_opc;
  logic [NP*IW-1:0]  slv_r_id;
  logic              mst_req;
  logic [AW-1:0]     mst_add;
  logic              mst_we_n;
  logic [BW-1:0]     mst_be;
  logic [DW-1:0]     mst_wdata;
  logic [IW-1:0]     mst_id;
  logic              mst_gnt;
  logic              mst_r_valid;
  logic [DW-1:0]     mst_r_rdata;
  logic              mst_r_opc;
  logic [IW-1:0]     mst_r_id;
  logic              busy;
  logic              rsp_err;

  int assertions = 0;
  int failures   = 0;

  dmac_ctrl_port_mux dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_slv_req     (slv_req),
    .i_slv_add     (slv_add),
    .i_slv_we_n    (slv_we_n),
    .i_slv_be      (slv_be),
    .i_slv_wdata   (slv_wdata),
    .i_slv_id      (slv_id),
    .o_slv_gnt     (slv_gnt),
    .o_slv_r_valid (slv_r_valid),
    .o_slv_r_rdata (slv_r_rdata),
    .o_slv_r_opc   (slv_r_opc),
    .o_slv_r_id    (slv_r_id),
    .o_mst_req     (mst_req),
    .o_mst_add     (mst_add),
    .o_mst_we_n    (mst_we_n),
    .o_mst_be      (mst_be),
    .o_mst_wdata   (mst_wdata),
    .o_mst_id      (mst_id),
    .i_mst_gnt     (mst_gnt),
    .i_mst_r_valid (mst_r_valid),
    .i_mst_r_rdata (mst_r_rdata),
    .i_mst_r_opc   (mst_r_opc),
    .i_mst_r_id    (mst_r_id),
    .o_busy        (busy),
    .o_rsp_err     (rsp_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clearInputs();
    slv_req     = '0;
    slv_add     = '0;
    slv_we_n    = '1;
    slv_be      = '0;
    slv_wdata   = '0;
    slv_id      = '0;
    mst_gnt     = 1'b0;
    mst_r_valid = 1'b0;
    mst_r_rdata = '0;
    mst_r_opc   = 1'b0;
    mst_r_id    = '0;
  endtask

  task automatic applyStimulus(input int port, input ctrl_req_t r);
    slv_req[port]              = 1'b1;
    slv_add[port*AW +: AW]     = r.add;
    slv_we_n[port]             = r.we_n;
    slv_be[port*BW +: BW]      = r.be;
    slv_wdata[port*DW +: DW]   = r.wdata;
    slv_id[port*IW +: IW]      = r.id;
  endtask

  task automatic respond(input logic v, input logic [DW-1:0] d, input logic [IW-1:0] id);
    mst_r_valid = v;
    mst_r_rdata = d;
    mst_r_opc   = 1'b0;
    mst_r_id    = id;
  endtask

  task automatic doReset();
    clearInputs();
    i_rst_n = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hs;
    int ord_port [3];
    logic [DW-1:0] ord_data [3];
    ord_port = '{7, 2, 5};
    ord_data = '{32'hA, 32'hB, 32'hC};

    // Reset values
    clearInputs();
    #1 i_rst_n = 1'b0;
    #2;
    checkOutput("rst_r_valid", 64'(slv_r_valid), 64'h0);
    checkOutput("rst_rdata", 64'(|slv_r_rdata), 64'h0);
    checkOutput("rst_r_id", 64'(|slv_r_id), 64'h0);
    checkOutput("rst_opc", 64'(slv_r_opc), 64'h0);
    checkOutput("rst_err", 64'(rsp_err), 64'h0);
    checkOutput("rst_busy", 64'(busy), 64'h0);
    checkOutput("rst_mst_req", 64'(mst_req), 64'h0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // Single port: port 3 write, response two cycles after the handshake
    applyStimulus(3, '{add: 10'h010, we_n: 1'b0, be: 4'hF, wdata: 32'hCAFE0001, id: 4'h5});
    mst_gnt = 1'b1;
    #1;
    checkOutput("single_gnt", 64'(slv_gnt), 64'h008);
    checkOutput("single_mst_req", 64'(mst_req), 64'h1);
    checkOutput("single_add", 64'(mst_add), 64'h010);
    checkOutput("single_wdata", 64'(mst_wdata), 64'hCAFE0001);
    checkOutput("single_we_n", 64'(mst_we_n), 64'h0);
    checkOutput("single_be", 64'(mst_be), 64'hF);
    checkOutput("single_id", 64'(mst_id), 64'h5);
    tick();
    clearInputs();
    #1;
    checkOutput("single_busy", 64'(busy), 64'h1);
    checkOutput("single_rv_early", 64'(slv_r_valid), 64'h0);
    tick();
    respond(1'b1, 32'h12345678, 4'h5);
    tick();
    respond(1'b0, '0, '0);
    #1;
    checkOutput("single_rv", 64'(slv_r_valid), 64'h008);
    checkOutput("single_rdata", 64'(slv_r_rdata[3*DW +: DW]), 64'h12345678);
    checkOutput("single_rid", 64'(slv_r_id[3*IW +: IW]), 64'h5);
    tick();
    #1;
    checkOutput("single_rv_off", 64'(slv_r_valid), 64'h0);
    checkOutput("single_idle", 64'(busy), 64'h0);

    // Fairness: everyone requests, responses come back immediately
    doReset();
    slv_req = '1;
    mst_gnt = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      respond(i > 0, DW'(i), IW'(i));
      #1;
      checkOutput($sformatf("fair_gnt%0d", i), 64'(slv_gnt), 64'(1) << (i % 10));
      if (i >= 2) checkOutput($sformatf("fair_rv%0d", i), 64'(slv_r_valid), 64'(1) << ((i - 2) % 10));
      tick();
    end
    slv_req = '0;
    mst_gnt = 1'b0;
    respond(1'b1, 32'h77, 4'h0);
    #1;
    checkOutput("fair_rv_p9", 64'(slv_r_valid), 64'h200);
    tick();
    respond(1'b0, '0, '0);
    #1;
    checkOutput("fair_rv_p0", 64'(slv_r_valid), 64'h001);
    tick();
    #1;
    checkOutput("fair_idle", 64'(busy), 64'h0);

    // Back-pressure: responses withheld until the FIFO fills
    doReset();
    slv_req = '1;
    mst_gnt = 1'b1;
    hs = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (slv_gnt != '0) hs++;
      tick();
    end
    checkOutput("bp_handshakes", 64'(hs), 64'd4);
    #1;
    checkOutput("bp_req_full", 64'(mst_req), 64'h0);
    respond(1'b1, 32'hB0, 4'h0);
    #1;
    checkOutput("bp_req_pop_cycle", 64'(mst_req), 64'h0);
    tick();
    respond(1'b0, '0, '0);
    mst_gnt = 1'b0;
    #1;
    checkOutput("bp_req_freed", 64'(mst_req), 64'h1);
    checkOutput("bp_rv0", 64'(slv_r_valid), 64'h001);
    respond(1'b1, 32'hB1, 4'h0);
    for (int j = 1; j <= 3; j++) begin
      tick();
      #1;
      checkOutput($sformatf("bp_rv%0d", j), 64'(slv_r_valid), 64'(1) << j);
    end
    respond(1'b0, '0, '0);
    slv_req = '0;
    tick();
    #1;
    checkOutput("bp_idle", 64'(busy), 64'h0);

    // Ordering: ports 7, 2, 5 granted in turn, responses routed in order
    doReset();
    for (int j = 0; j < 3; j++) begin
      clearInputs();
      mst_gnt = 1'b1;
      slv_req[ord_port[j]] = 1'b1;
      #1;
      checkOutput($sformatf("ord_gnt%0d", j), 64'(slv_gnt), 64'(1) << ord_port[j]);
      tick();
    end
    clearInputs();
    for (int j = 0; j < 3; j++) begin
      respond(1'b1, ord_data[j], IW'(j + 1));
      tick();
      #1;
      checkOutput($sformatf("ord_rv%0d", j), 64'(slv_r_valid), 64'(1) << ord_port[j]);
      checkOutput($sformatf("ord_data%0d", j), 64'(slv_r_rdata[ord_port[j]*DW +: DW]), 64'(ord_data[j]));
    end
    respond(1'b0, '0, '0);
    tick();
    #1;
    checkOutput("ord_hold_p7", 64'(slv_r_rdata[7*DW +: DW]), 64'hA);
    checkOutput("ord_hold_id_p2", 64'(slv_r_id[2*IW +: IW]), 64'h2);
    checkOutput("ord_rv_off", 64'(slv_r_valid), 64'h0);

    // Spurious response with the FIFO empty
    respond(1'b1, 32'hDEAD, 4'h0);
    tick();
    respond(1'b0, '0, '0);
    #1;
    checkOutput("spur_err", 64'(rsp_err), 64'h1);
    checkOutput("spur_rv", 64'(slv_r_valid), 64'h0);
    checkOutput("spur_busy", 64'(busy), 64'h0);
    tick();
    #1;
    checkOutput("spur_err_off", 64'(rsp_err), 64'h0);

    // Mid-flight reset with three outstanding transactions
    doReset();
    slv_req = '1;
    mst_gnt = 1'b1;
    tick();
    tick();
    tick();
    clearInputs();
    #1;
    checkOutput("mid_busy", 64'(busy), 64'h1);
    i_rst_n = 1'b0;
    #1;
    checkOutput("mid_busy_rst", 64'(busy), 64'h0);
    tick();
    i_rst_n = 1'b1;
    slv_req = 10'b00_0100_0010;
    mst_gnt = 1'b1;
    #1;
    checkOutput("mid_first_gnt", 64'(slv_gnt), 64'h002);
    tick();
    clearInputs();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
